// File: rtl/mul_div_unit_iter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mul_pkg                                                          |
// | Purpose  : Shared definitions for the iterative multiply / count unit:      |
// |            func codes, FSM state encoding and op-classification helpers.    |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package mul_pkg;

  localparam int FUNC_W = 6;

  // Op-select codes driven by the decoder on `func`.
  localparam logic [FUNC_W-1:0] MADD  = 6'h00;
  localparam logic [FUNC_W-1:0] MADDU = 6'h01;
  localparam logic [FUNC_W-1:0] MUL   = 6'h02;
  localparam logic [FUNC_W-1:0] MSUB  = 6'h04;
  localparam logic [FUNC_W-1:0] MSUBU = 6'h05;
  localparam logic [FUNC_W-1:0] MULT  = 6'h18;
  localparam logic [FUNC_W-1:0] MULTU = 6'h19;
  localparam logic [FUNC_W-1:0] CLZ   = 6'h20;
  localparam logic [FUNC_W-1:0] CLO   = 6'h21;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COUNT  = 2'd2,
    FINISH = 2'd3
  } state_e;

  // Signed multiply ops operate on magnitudes and fix the sign at the end.
  function automatic logic is_signed(input logic [FUNC_W-1:0] func);
    return (func == MUL) || (func == MULT) || (func == MADD) || (func == MSUB);
  endfunction

  function automatic logic is_count(input logic [FUNC_W-1:0] func);
    return (func == CLZ) || (func == CLO);
  endfunction

  function automatic logic is_valid_func(input logic [FUNC_W-1:0] func);
    return is_signed(func) || is_count(func) ||
           (func == MULTU) || (func == MADDU) || (func == MSUBU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_div_unit_iter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mul_div_unit_iter_if                                             |
// | Purpose  : Request / response bundle between the EX-stage decoder and the   |
// |            iterative multiply / count unit.                                 |
// | Ports    : master - decoder side (drives start/func/operands/flush/MTHI/LO) |
// |            slave  - unit side (drives busy/done/result/hi/lo)               |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface mul_div_unit_iter_if #(
  parameter int WIDTH = 32
) ();
  import mul_pkg::*;

  logic              start;
  logic [FUNC_W-1:0] func;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              flush;
  logic              wr_hi;
  logic              wr_lo;
  logic [WIDTH-1:0]  wr_data;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  result;
  logic [WIDTH-1:0]  hi;
  logic [WIDTH-1:0]  lo;

  modport master (
    output start, func, a, b, flush, wr_hi, wr_lo, wr_data,
    input  busy, done, result, hi, lo
  );

  modport slave (
    input  start, func, a, b, flush, wr_hi, wr_lo, wr_data,
    output busy, done, result, hi, lo
  );

endinterface
`default_nettype wire

// File: rtl/mul_div_unit_iter_clz_count.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : clz_count                                                        |
// | Purpose  : Combinational leading-zero counter. Returns WIDTH for an         |
// |            all-zero input. Leading ones are counted by feeding ~value.      |
// | Ports    : value (WIDTH in), count (CNT_W out)                              |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module clz_count #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic [WIDTH-1:0] value,
  output logic [CNT_W-1:0] count
);

  // Ascending scan: the highest set bit is the last to overwrite the count.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_div_unit_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mul_div_unit_iter                                                |
// | Purpose  : Iterative radix-2 multiply / multiply-accumulate unit with       |
// |            CLO/CLZ, owning the architectural HI/LO registers.               |
// | Ports    : clk, rst (sync, active high)                                     |
// |            bus (slave) - start/func/a/b/flush/wr_hi/wr_lo/wr_data in,       |
// |                          busy/done/result/hi/lo out                         |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mul_div_unit_iter
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  mul_div_unit_iter_if.slave  bus
);

  localparam int PW = 2 * WIDTH;

  state_e            state_q,  state_d;
  logic [FUNC_W-1:0] func_q,   func_d;
  logic              sign_q,   sign_d;
  logic [WIDTH-1:0]  a_q,      a_d;
  logic [WIDTH-1:0]  mcand_q,  mcand_d;
  logic [PW-1:0]     acc_q,    acc_d;
  logic [CNT_W-1:0]  iter_q,   iter_d;
  logic              busy_q,   busy_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [WIDTH-1:0]  hi_q,     hi_d;
  logic [WIDTH-1:0]  lo_q,     lo_d;

  logic              w_signed_op;
  logic [WIDTH-1:0]  w_mag_a;
  logic [WIDTH-1:0]  w_mag_b;
  logic [WIDTH:0]    w_sum;
  logic [PW-1:0]     w_step;
  logic [PW-1:0]     w_prod;
  logic [PW-1:0]     w_final;
  logic [CNT_W-1:0]  w_cnt;
  logic [WIDTH-1:0]  w_cnt_ext;
  logic              w_done;

  assign w_signed_op = is_signed(bus.func);
  assign w_mag_a     = (w_signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_mag_b     = (w_signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // acc holds {partial product, remaining multiplier bits}; the multiplier
  // LSB selects whether the multiplicand is added before the right shift.
  assign w_sum  = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & mcand_q};
  assign w_step = {w_sum, acc_q[WIDTH-1:1]};
  assign w_prod = sign_q ? -w_step : w_step;

  // Final {hi,lo} (or MUL product) is staged into acc on the last CALC edge.
  // HI/LO cannot change while busy, so accumulating against hi_q/lo_q here
  // matches committing in FINISH.
  always_comb begin
    w_final = w_prod;
    if ((func_q == MADD) || (func_q == MADDU)) begin
      w_final = {hi_q, lo_q} + w_prod;
    end else if ((func_q == MSUB) || (func_q == MSUBU)) begin
      w_final = {hi_q, lo_q} - w_prod;
    end
  end

  clz_count #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_clz_count (
    .value ((func_q == CLO) ? ~a_q : a_q),
    .count (w_cnt)
  );

  assign w_cnt_ext = {{(WIDTH - CNT_W){1'b0}}, w_cnt};

  // done is qualified by flush in the same cycle so a flush landing on the
  // completing cycle suppresses both the pulse and the HI/LO/result commit.
  assign w_done     = ((state_q == FINISH) || (state_q == COUNT)) && !bus.flush;
  assign bus.done   = w_done;
  assign bus.busy   = busy_q;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
  assign bus.result = !w_done ? result_q
                    : ((state_q == COUNT) ? w_cnt_ext : acc_q[WIDTH-1:0]);

  always_comb begin
    state_d  = state_q;
    func_d   = func_q;
    sign_d   = sign_q;
    a_d      = a_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    iter_d   = iter_q;
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      IDLE: begin
        if (bus.wr_hi) hi_d = bus.wr_data;
        if (bus.wr_lo) lo_d = bus.wr_data;
        if (bus.start && !bus.flush && is_valid_func(bus.func)) begin
          func_d  = bus.func;
          a_d     = bus.a;
          sign_d  = w_signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          mcand_d = w_mag_a;
          acc_d   = {{WIDTH{1'b0}}, w_mag_b};
          iter_d  = CNT_W'(WIDTH - 1);
          state_d = is_count(bus.func) ? COUNT : CALC;
        end
      end

      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (iter_q == '0) begin
          acc_d   = w_final;
          state_d = FINISH;
        end else begin
          acc_d  = w_step;
          iter_d = iter_q - 1'b1;
        end
      end

      COUNT: begin
        if (!bus.flush) result_d = w_cnt_ext;
        state_d = IDLE;
      end

      FINISH: begin
        if (!bus.flush) begin
          result_d = acc_q[WIDTH-1:0];
          if (func_q != MUL) begin
            hi_d = acc_q[PW-1:WIDTH];
            lo_d = acc_q[WIDTH-1:0];
          end
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      func_q   <= '0;
      sign_q   <= 1'b0;
      a_q      <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      iter_q   <= '0;
      busy_q   <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      func_q   <= func_d;
      sign_q   <= sign_d;
      a_q      <= a_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      iter_q   <= iter_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/mul_div_unit_iter.md
Name: mul_div_unit_iter

Overview:
- Iterative multiply / count-leading unit in the EX stage. It is the responder to the pipeline stall logic.
- The decoder issues a MUL-class op with a one-cycle `start` pulse. This unit holds `busy` until the result is ready, then pulses `done`.
- It owns the architectural HI/LO registers. The hazard logic ORs `busy` into the pipeline stall.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH. The iteration count equals WIDTH.
- CNT_W, 6, width of the CLO/CLZ count (clog2(WIDTH)+1). The count is zero-extended onto `result`.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  op request; sampled only in IDLE
- func  in  6  op select: MUL, MULT, MULTU, MADD, MADDU, MSUB, MSUBU, CLO, CLZ (codes from shared package)
- a  in  WIDTH  rs operand
- b  in  WIDTH  rt operand
- flush  in  1  kill the in-flight op (branch/exception)
- wr_hi  in  1  MTHI write
- wr_lo  in  1  MTLO write
- wr_data  in  WIDTH  data for MTHI/MTLO
- busy  out  1  high while an op is in flight
- done  out  1  one-cycle pulse; `result` valid this cycle
- result  out  WIDTH  GPR writeback value
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset values:
  - state=IDLE
  - busy=0, done=0, result=0, hi=0, lo=0
  - internal accumulator and counter cleared
- Reset mid-operation aborts the op with no `done`.
- `busy` = (state != IDLE). It is registered, so it rises the cycle after `start`.
- States: IDLE, CALC, COUNT, FINISH.
- IDLE, with `start` and no `flush`:
  - Latch func, |a|, |b| (signed ops take two's-complement magnitude) and the result sign a[MSB]^b[MSB]; the sign is 0 for unsigned ops.
  - Then: CLO/CLZ -> COUNT; all other ops -> CALC with iter=WIDTH-1.
- IDLE, unknown func with `start`: ignored; the unit stays IDLE.
- CALC: radix-2 shift-add, one multiplier bit per cycle into a 2*WIDTH accumulator. At iter==0 -> FINISH. CALC lasts WIDTH cycles.
- FINISH:
  - Negate the product if sign=1.
  - Update by op:
    - MUL: `result` = low WIDTH bits; HI/LO unchanged.
    - MULT/MULTU: {hi,lo}=product.
    - MADD/MADDU: {hi,lo}+=product, modulo 2^(2*WIDTH).
    - MSUB/MSUBU: {hi,lo}-=product.
    - Non-MUL ops: `result`=new lo.
  - done=1 for one cycle, then -> IDLE.
- COUNT: `result` = number of leading ones (CLO) or leading zeros (CLZ) of latched `a`; the count is WIDTH when all bits match. done=1, then -> IDLE. HI/LO unchanged.
- Latency from the `start` cycle T:
  - MUL family: busy T+1..T+WIDTH+1; done at T+WIDTH+1 (T+33).
  - CLO/CLZ: busy and done at T+1.
- `start` while busy is ignored; the stall logic guarantees it is not issued.
- `flush` in CALC/COUNT/FINISH -> IDLE next cycle. No `done`, HI/LO unchanged. This includes FINISH: flush wins over the update.
- `flush` together with `start` in IDLE: `start` is dropped.
- wr_hi/wr_lo apply only in IDLE; while busy they are ignored.
  - Same cycle as `start`: the write is applied, and the MADD/MSUB accumulate in FINISH uses the written value.
  - wr_hi and wr_lo together: both are written.
- `result` holds its last value between ops.

Decomposition:
- Shared package mul_pkg holds:
  - the func code localparams: MUL, MULT, MULTU, MADD, MADDU, MSUB, MSUBU, CLO, CLZ
  - the state enum: IDLE, CALC, COUNT, FINISH
  - an is_signed(func) helper function
- One sub-module, clz_count: combinational leading-zero counter, WIDTH in, CNT_W out.
  - CLO is CLZ of ~a.

Test Plan:
- MULT a=-3 (0xFFFFFFFD), b=7 -> done at T+33; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high exactly 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then MADDU a=1, b=1 -> lo=0x00000002, hi unchanged.
- MSUB with hi=0, lo=0, a=2, b=3 -> {hi,lo}=0xFFFFFFFF_FFFFFFFA. Then MUL a=0x10000, b=0x10000 -> result=0, HI/LO unchanged.
- CLZ a=0x00010000 -> result=15 at T+1. CLO a=0xFFFFFFFF -> 32. CLZ a=0 -> 32.
- MULT started, flush at T+10 -> busy low at T+11, no done, HI/LO keep their prior values. rst at T+20 of a new op -> all outputs 0 next cycle.
- wr_lo=1, wr_data=5 with MADD a=2, b=2 in the same cycle -> lo=9. start pulsed during busy -> ignored, exactly one done.
